// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a show-ahead receive FIFO.
// Ports:
//   clock, reset          system clock; synchronous active-low reset
//   baud_div              oversample tick every baud_div+1 clocks
//   parity, width, stop2  frame format, latched at start-bit detection
//   in                    async serial line, idle high
//   rx_ready              consumer pops the head entry when rx_valid
//   clear_overflow        clears the sticky overflow flag
//   rx_valid, rx_data, rx_error_parity, rx_error_stop, rx_break
//                         head entry of the FIFO (all zero when empty)
//   overflow              sticky: a completed frame was dropped on a full FIFO
//   busy                  receiver is inside a frame or waiting out a break
//   level                 FIFO occupancy
module uart_rx_fifo #(
  parameter int unsigned DATA_MAX   = 16,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DIV_WIDTH-1:0]             baud_div,
  input  logic [1:0]                       parity,
  input  logic [$clog2(DATA_MAX+1)-1:0]    width,
  input  logic                             stop2,
  input  logic                             in,
  input  logic                             rx_ready,
  input  logic                             clear_overflow,
  output logic                             rx_valid,
  output logic [DATA_MAX-1:0]              rx_data,
  output logic                             rx_error_parity,
  output logic                             rx_error_stop,
  output logic                             rx_break,
  output logic                             overflow,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level
);

  localparam int unsigned WID_W   = $clog2(DATA_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(DATA_MAX);
  localparam int unsigned N_W     = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = DATA_MAX + 3;
  localparam int unsigned M       = OVERSAMPLE / 2;

  localparam logic [N_W-1:0] N_V0   = N_W'(M - 1);
  localparam logic [N_W-1:0] N_V1   = N_W'(M);
  localparam logic [N_W-1:0] N_DEC  = N_W'(M + 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

  state_t               state, state_nx;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 tick, s1, s_in, armed;
  logic [N_W-1:0]       n;
  logic                 v0, v1, bit_maj, dec, wrap, start_det;
  logic [WID_W-1:0]     bit_cnt, wid_l, wid_eff;
  logic [DATA_MAX-1:0]  data_r;
  logic                 acc, perr, stop1_bit, par_en_l, par_odd_l, stop2_l;
  logic                 push, brk_c, serr_c;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_nx;
  logic                 pop, full, do_write, drop;

  // Baud tick: counter 0..baud_div, tick on the terminal count.
  assign tick = (cnt == baud_div);
  always_ff @(posedge clock) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + DIV_WIDTH'(1);
  end

  // Two-flop synchroniser; armed blocks start detection until the line has been seen idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1    <= 1'b1;
      s_in  <= 1'b1;
      armed <= 1'b0;
    end else begin
      s1   <= in;
      s_in <= s1;
      if (tick && s_in) armed <= 1'b1;
    end
  end

  assign bit_maj   = (v0 & v1) | (v0 & s_in) | (v1 & s_in);
  assign dec       = tick && (n == N_DEC);
  assign wrap      = tick && (n == N_LAST);
  assign start_det = tick && armed && !s_in;
  assign wid_eff   = (width == '0 || width > WID_W'(DATA_MAX)) ? WID_W'(DATA_MAX) : width;

  // Break/stop error for the push decision; in STOP1 without stop2 the first-stop term drops out.
  assign brk_c  = (data_r == '0) && !bit_maj && (!stop2_l || !stop1_bit);
  assign serr_c = !bit_maj || (stop2_l && !stop1_bit);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and push strobe.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE:    if (start_det) state_nx = START;
      START: begin
        if (dec && bit_maj) state_nx = IDLE;
        else if (wrap)      state_nx = DATA;
      end
      DATA:    if (wrap && bit_cnt == wid_l) state_nx = par_en_l ? PARITY : STOP1;
      PARITY:  if (wrap) state_nx = STOP1;
      STOP1: begin
        if (dec && !stop2_l) begin
          push     = 1'b1;
          state_nx = brk_c ? BRKWAIT : IDLE;
        end else if (wrap && stop2_l) begin
          state_nx = STOP2;
        end
      end
      STOP2: begin
        if (dec) begin
          push     = 1'b1;
          state_nx = brk_c ? BRKWAIT : IDLE;
        end
      end
      BRKWAIT: if (tick && s_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sample index, votes, shift-in and frame-format latch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      n         <= '0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      bit_cnt   <= '0;
      data_r    <= '0;
      acc       <= 1'b0;
      perr      <= 1'b0;
      stop1_bit <= 1'b1;
      wid_l     <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
    end else if (state == IDLE) begin
      if (start_det) begin
        n         <= '0;
        bit_cnt   <= '0;
        data_r    <= '0;
        acc       <= 1'b0;
        perr      <= 1'b0;
        stop1_bit <= 1'b1;
        wid_l     <= wid_eff;
        par_en_l  <= parity[1];
        par_odd_l <= parity[0];
        stop2_l   <= stop2;
      end
    end else if (tick) begin
      n <= (n == N_LAST) ? '0 : n + N_W'(1);
      if (n == N_V0) v0 <= s_in;
      if (n == N_V1) v1 <= s_in;
      if (n == N_DEC) begin
        case (state)
          DATA: begin
            data_r[bit_cnt[IDX_W-1:0]] <= bit_maj;
            acc                        <= acc ^ bit_maj;
            bit_cnt                    <= bit_cnt + WID_W'(1);
          end
          PARITY:  perr      <= acc ^ bit_maj ^ par_odd_l;
          STOP1:   stop1_bit <= bit_maj;
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  // Receive FIFO: a push into a full FIFO only lands if the head is popped in the same cycle.
  assign pop      = rx_valid && rx_ready;
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    level_nx = level;
    case ({do_write, pop})
      2'b10:   level_nx = level + LVL_W'(1);
      2'b01:   level_nx = level - LVL_W'(1);
      default: level_nx = level;
    endcase
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= {brk_c, serr_c, perr, data_r};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level_nx;
      rx_valid <= (level_nx != '0);
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Show-ahead head outputs, forced to zero when empty.
  assign head            = mem[rd_ptr];
  assign rx_data         = rx_valid ? head[DATA_MAX-1:0] : '0;
  assign rx_error_parity = rx_valid && head[DATA_MAX];
  assign rx_error_stop   = rx_valid && head[DATA_MAX+1];
  assign rx_break        = rx_valid && head[DATA_MAX+2];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at baud_div=0, 8x oversampling, 16-bit data, 4-deep FIFO.
module tb_uart_rx_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity;
  logic [4:0]  width;
  logic        stop2;
  logic        in;
  logic        rx_ready;
  logic        clear_overflow;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_error_parity;
  logic        rx_error_stop;
  logic        rx_break;
  logic        overflow;
  logic        busy;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(
    .DATA_MAX(16), .OVERSAMPLE(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .baud_div(baud_div), .parity(parity),
    .width(width), .stop2(stop2), .in(in), .rx_ready(rx_ready),
    .clear_overflow(clear_overflow), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error_parity(rx_error_parity), .rx_error_stop(rx_error_stop),
    .rx_break(rx_break), .overflow(overflow), .busy(busy), .level(level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
  endtask

  // One line bit per 8 clocks, bits[0] first; call on a negedge.
  task automatic send_bits(input logic [31:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      in = bits[i];
      cyc(8);
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] d,
                          input logic pe, input logic se, input logic bk);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"},  32'(rx_data), 32'(d));
    chk({tag, "_perr"},  32'(rx_error_parity), 32'(pe));
    chk({tag, "_serr"},  32'(rx_error_stop), 32'(se));
    chk({tag, "_brk"},   32'(rx_break), 32'(bk));
  endtask

  initial begin
    reset = 1'b0; baud_div = 16'd0; parity = 2'b00; width = 5'd8; stop2 = 1'b0;
    in = 1'b1; rx_ready = 1'b0; clear_overflow = 1'b0;
    cyc(3);
    // Reset state
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_data",  32'(rx_data), 32'd0);
    reset = 1'b1;
    cyc(4);

    // 8N1 0xA5 with rx_ready=1: push at the stop-bit decision, visible one cycle later
    rx_ready = 1'b1;
    send_bits(32'({1'b1, 8'hA5, 1'b0}), 10);
    chk("a5_pre_valid", 32'(rx_valid), 32'd0);
    chk("a5_pre_busy",  32'(busy), 32'd1);
    cyc(1);
    chk_head("a5", 16'h00A5, 1'b0, 1'b0, 1'b0);
    chk("a5_level", 32'(level), 32'd1);
    chk("a5_busy",  32'(busy), 32'd0);
    cyc(1);
    chk("a5_popped_valid", 32'(rx_valid), 32'd0);
    chk("a5_popped_level", 32'(level), 32'd0);
    rx_ready = 1'b0;
    cyc(8);

    // 7E1 0x41 with parity bit 1 -> parity error
    width = 5'd7; parity = 2'b10;
    send_bits(32'({1'b1, 1'b1, 7'h41, 1'b0}), 10);
    cyc(2);
    chk_head("par", 16'h0041, 1'b1, 1'b0, 1'b0);
    pop_one();
    chk("par_level", 32'(level), 32'd0);
    width = 5'd8; parity = 2'b00;
    cyc(8);

    // Glitch of 3 ticks -> false start, nothing stored
    in = 1'b0;
    cyc(3);
    in = 1'b1;
    cyc(2);
    chk("fs_busy_in", 32'(busy), 32'd1);
    cyc(7);
    chk("fs_busy_out", 32'(busy), 32'd0);
    chk("fs_level",    32'(level), 32'd0);
    cyc(16);

    // Break: 12 bit times low -> exactly one entry, held until the line returns high
    in = 1'b0;
    cyc(96);
    chk("brk_level", 32'(level), 32'd1);
    chk_head("brk", 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("brk_busy", 32'(busy), 32'd1);
    in = 1'b1;
    cyc(10);
    chk("brk_busy_after", 32'(busy), 32'd0);
    chk("brk_level_after", 32'(level), 32'd1);
    pop_one();
    chk("brk_popped", 32'(level), 32'd0);
    cyc(8);

    // Stop bit low with nonzero data -> stop error, not a break
    send_bits(32'({1'b0, 8'h80, 1'b0}), 10);
    in = 1'b1;
    cyc(24);
    chk("serr_level", 32'(level), 32'd1);
    chk_head("serr", 16'h0080, 1'b0, 1'b1, 1'b0);
    pop_one();
    cyc(8);

    // Five frames into a 4-deep FIFO with no consumer -> overflow
    for (int k = 1; k <= 5; k++) send_bits(32'({1'b1, 8'(k), 1'b0}), 10);
    cyc(4);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag",  32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), 32'(rx_data), 32'(k));
      pop_one();
    end
    chk("ovf_empty", 32'(level), 32'd0);
    chk("ovf_still", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cyc(8);

    // Reset mid-frame discards the frame and the FIFO; then 16-bit, 2-stop 0xBEEF
    send_bits(32'({1'b1, 8'h33, 1'b0}), 10);
    cyc(2);
    chk("pre_rst_level", 32'(level), 32'd1);
    send_bits(32'({5'h1A, 1'b0}), 6);
    in = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    cyc(4);
    width = 5'd16; stop2 = 1'b1;
    send_bits(32'({2'b11, 16'hBEEF, 1'b0}), 19);
    cyc(2);
    chk("beef_level", 32'(level), 32'd1);
    chk_head("beef", 16'hBEEF, 1'b0, 1'b0, 1'b0);
    pop_one();
    chk("beef_popped", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
